// File: rtl/out_ports_mmio.sv
// Memory-mapped output ports: HEX/LED/BLINK/CTRL registers driving seven-segment digits and LEDs.
// Optional iterative binary-to-BCD converter on register 4, enabled by defining OUT_PORTS_BCD_EN.
module out_ports_mmio #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_LEDS   = 10,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [2:0]              addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_LEDS-1:0]     led,
  output logic                    busy
);

  localparam int HW = 4 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [2:0] A_HEX   = 3'd0;
  localparam logic [2:0] A_LED   = 3'd1;
  localparam logic [2:0] A_BLINK = 3'd2;
  localparam logic [2:0] A_CTRL  = 3'd3;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [HW-1:0]         hex_q, hex_d;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  logic                  conv_done;
  logic [HW-1:0]         conv_result;

  logic                  unused_wdata;
  assign unused_wdata = ^wdata;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

`ifdef OUT_PORTS_BCD_EN
  localparam logic [2:0] A_BCD = 3'd4;

  typedef enum logic {ST_IDLE, ST_CONV} bcd_state_e;

  bcd_state_e  state_q, state_d;
  logic [26:0] bin_q, bin_d;
  logic [35:0] bcd_q, bcd_d, bcd_shift;
  logic [4:0]  step_q, step_d;

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_shift = bcd_q;
    for (int i = 0; i < 9; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_shift[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_shift[34:0], bin_q[26]};
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    step_d    = step_q;
    conv_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en && addr == A_BCD) begin
          bin_d   = wdata[26:0];
          bcd_d   = '0;
          step_d  = '0;
          state_d = ST_CONV;
        end
      end
      default: begin
        bin_d  = {bin_q[25:0], 1'b0};
        bcd_d  = bcd_shift;
        step_d = step_q + 5'd1;
        if (step_q == 5'd26) begin
          conv_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
    end
  end

  assign busy        = (state_q == ST_CONV);
  assign conv_result = bcd_shift[HW-1:0];
`else
  assign busy        = 1'b0;
  assign conv_done   = 1'b0;
  assign conv_result = '0;
`endif

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    hex_d   = hex_q;
    led_d   = led_q;
    blink_d = blink_q;
    ctrl_d  = ctrl_q;
    if (wr_en) begin
      case (addr)
        A_HEX:   if (!busy) hex_d = wdata[HW-1:0];
        A_LED:   led_d   = wdata[NUM_LEDS-1:0];
        A_BLINK: blink_d = wdata[NUM_DIGITS-1:0];
        A_CTRL:  ctrl_d  = wdata[1:0];
        default: ;
      endcase
    end
    if (conv_done) hex_d = conv_result;
  end

  // Blink timebase runs independently of writes and of the display enable.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      hex_q   <= '0;
      led_q   <= '0;
      blink_q <= '0;
      ctrl_q  <= 2'b10;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      led_q   <= led_d;
      blink_q <= blink_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  logic [3:0] nib;
  logic [6:0] seg;
  logic       all_zero;

  // Walk digits from the top so all_zero means "this nibble and every higher one are 0".
  always_comb begin
    hex_out  = '0;
    nib      = '0;
    seg      = SEG_OFF;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib      = hex_q[4*k +: 4];
      all_zero = all_zero & (nib == 4'd0);
      if (!ctrl_q[1])                        seg = SEG_OFF;
      else if (blink_q[k] && phase_q)        seg = SEG_OFF;
      else if (ctrl_q[0] && all_zero && k > 0) seg = SEG_OFF;
      else                                   seg = glyph(nib);
      hex_out[7*k +: 7] = seg;
    end
    led = ctrl_q[1] ? led_q : '0;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_HEX:   rdata[HW-1:0]         = hex_q;
      A_LED:   rdata[NUM_LEDS-1:0]   = led_q;
      A_BLINK: rdata[NUM_DIGITS-1:0] = blink_q;
      A_CTRL:  rdata[1:0]            = ctrl_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_out_ports_mmio.sv
// Self-checking bench for out_ports_mmio: directed table, blink/BCD sequences, randomized model check.
module tb_out_ports_mmio;

  localparam int ND = 6;
  localparam int NL = 10;
  localparam int BD = 4;
  localparam int HW = 4 * ND;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] GA = 7'h08;
  localparam logic [6:0] GF = 7'h0E;
  localparam logic [6:0] BL = 7'h7F;

  logic           clock = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [2:0]     addr;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic [7*ND-1:0] hex_out;
  logic [NL-1:0]  led;
  logic           busy;

  out_ports_mmio #(.NUM_DIGITS(ND), .NUM_LEDS(NL), .BLINK_DIV(BD)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hex_out(hex_out), .led(led), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Rising edges since reset was last released; the blink phase follows from it.
  int unsigned n_cyc = 0;
  always @(posedge clock) begin
    if (reset) n_cyc <= 0;
    else       n_cyc <= n_cyc + 1;
  end

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [31:0] m_hex, m_led, m_blink, m_ctrl;
  bit          m_busy;

  task automatic model_reset();
    m_hex = 0; m_led = 0; m_blink = 0; m_ctrl = 2; m_busy = 0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: if (!m_busy) m_hex = d & ((32'h1 << HW) - 32'h1);
      3'd1: m_led   = d & ((32'h1 << NL) - 32'h1);
      3'd2: m_blink = d & ((32'h1 << ND) - 32'h1);
      3'd3: m_ctrl  = d & 32'h3;
      default: ;
    endcase
  endtask

  function automatic logic [7*ND-1:0] model_hex();
    logic [7*ND-1:0] r;
    int unsigned nib;
    bit phase;
    logic [6:0] s;
    r = '0;
    phase = ((n_cyc / BD) % 2) == 1;
    for (int k = 0; k < ND; k++) begin
      nib = (m_hex >> (4*k)) & 32'hF;
      if (!m_ctrl[1])                                 s = BL;
      else if (m_blink[k] && phase)                   s = BL;
      else if (m_ctrl[0] && k > 0 && (m_hex >> (4*k)) == 0) s = BL;
      else                                            s = glyph_tab[nib];
      r[7*k +: 7] = s;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] a);
    case (a)
      3'd0: return m_hex;
      3'd1: return m_led;
      3'd2: return m_blink;
      3'd3: return m_ctrl;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = 0;
    x = v;
    for (int k = 0; k < ND; k++) begin
      r = r | ((x % 10) << (4*k));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_model(input string tag, input logic [2:0] ra);
    addr = ra;
    #1;
    check({tag, "_hex"}, hex_out, model_hex());
    check({tag, "_led"}, led, m_ctrl[1] ? m_led[NL-1:0] : '0);
    check({tag, "_rdata"}, rdata, model_rdata(ra));
  endtask

  typedef struct packed {
    logic [2:0]      wa;
    logic [31:0]     wd;
    logic [2:0]      ra;
    logic [31:0]     exp_rdata;
    logic [7*ND-1:0] exp_hex;
    logic [NL-1:0]   exp_led;
  } vec_t;

  vec_t vecs [15];

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  int blank_cnt;
  int busy_cnt;
  int unsigned rv;
  logic [2:0] ra, wa;
  logic we;
  logic [31:0] wd;

`ifdef OUT_PORTS_BCD_EN
  task automatic bcd_convert(input int unsigned v, input bit poke);
    @(negedge clock);
    wr_en = 1'b1; addr = 3'd4; wdata = v;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    m_busy = 1;
    check("bcd_busy_start", busy, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      busy_cnt++;
      wr_en = 1'b0;
      if (poke && busy_cnt == 3) begin wr_en = 1'b1; addr = 3'd0; wdata = 32'hFFFFFF; end
      if (poke && busy_cnt == 6) begin wr_en = 1'b1; addr = 3'd4; wdata = 32'd1; end
    end
    wr_en = 1'b0;
    check("bcd_busy_cycles", busy_cnt, 27);
    m_busy = 0;
    m_hex  = to_bcd(v);
    check_model("bcd_done", 3'd0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; addr = 3'd0; wdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    addr = 3'd3;
    #1;
    check("reset_hex", hex_out, {ND{G0}});
    check("reset_led", led, '0);
    check("reset_ctrl", rdata, 32'd2);
    check("reset_busy", busy, 1'b0);

    vecs[0]  = '{3'd3, 32'd2,          3'd3, 32'd2,        {ND{G0}},               10'h000};
    vecs[1]  = '{3'd0, 32'h00A5F0,     3'd0, 32'h00A5F0,   {G0, G0, GA, G5, GF, G0}, 10'h000};
    vecs[2]  = '{3'd3, 32'd3,          3'd3, 32'd3,        {BL, BL, GA, G5, GF, G0}, 10'h000};
    vecs[3]  = '{3'd1, 32'h3FF,        3'd1, 32'h3FF,      {BL, BL, GA, G5, GF, G0}, 10'h3FF};
    vecs[4]  = '{3'd3, 32'd0,          3'd1, 32'h3FF,      {ND{BL}},               10'h000};
    vecs[5]  = '{3'd3, 32'd2,          3'd3, 32'd2,        {G0, G0, GA, G5, GF, G0}, 10'h3FF};
    vecs[6]  = '{3'd0, 32'hFFFFFFFF,   3'd0, 32'h00FFFFFF, {ND{GF}},               10'h3FF};
    vecs[7]  = '{3'd5, 32'hDEAD,       3'd5, 32'h0,        {ND{GF}},               10'h3FF};
    vecs[8]  = '{3'd2, 32'hFFFFFFC0,   3'd2, 32'h0,        {ND{GF}},               10'h3FF};
    vecs[9]  = '{3'd3, 32'd3,          3'd3, 32'd3,        {ND{GF}},               10'h3FF};
    vecs[10] = '{3'd0, 32'h0,          3'd0, 32'h0,        {BL, BL, BL, BL, BL, G0}, 10'h3FF};
    vecs[11] = '{3'd0, 32'h010000,     3'd0, 32'h010000,   {BL, G1, G0, G0, G0, G0}, 10'h3FF};
    vecs[12] = '{3'd1, 32'hFFFFF000,   3'd1, 32'h0,        {BL, G1, G0, G0, G0, G0}, 10'h000};
    vecs[13] = '{3'd7, 32'h12345678,   3'd0, 32'h010000,   {BL, G1, G0, G0, G0, G0}, 10'h000};
    vecs[14] = '{3'd3, 32'd2,          3'd3, 32'd2,        {G0, G1, G0, G0, G0, G0}, 10'h000};

    for (int i = 0; i < 15; i++) begin
      do_write(vecs[i].wa, vecs[i].wd);
      addr = vecs[i].ra;
      #1;
      check($sformatf("vec%0d_hex", i), hex_out, vecs[i].exp_hex);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

`ifndef OUT_PORTS_BCD_EN
    do_write(3'd4, 32'd123456);
    addr = 3'd4;
    #1;
    check("addr4_rdata", rdata, 32'h0);
    check("addr4_busy", busy, 1'b0);
    check_model("addr4_nochange", 3'd0);
`endif

    // Blink: digit 0 must be dark for exactly half of any 24 consecutive cycles.
    do_reset();
    do_write(3'd2, 32'h01);
    do_write(3'd0, 32'h1);
    blank_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      addr = 3'd2;
      #1;
      if (hex_out[6:0] == BL) blank_cnt++;
      check($sformatf("blink%0d_hex", i), hex_out, model_hex());
    end
    check("blink_dark_count", blank_cnt, 12);

    // Randomized writes, including ones landing on blink wrap cycles.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      we = 1'($urandom_range(0, 1));
      wa = 3'($urandom_range(0, 7));
      if (wa == 3'd4) wa = 3'd3;
      rv = $urandom;
      case ($urandom_range(0, 3))
        0: wd = rv & 32'h0000000F;
        1: wd = rv & 32'h000F0F00;
        default: wd = rv;
      endcase
      wr_en = we; addr = wa; wdata = wd;
      @(posedge clock);
      #1;
      wr_en = 1'b0;
      if (we) model_write(wa, wd);
      ra = 3'($urandom_range(0, 7));
      check_model($sformatf("rand%0d", i), ra);
    end

`ifdef OUT_PORTS_BCD_EN
    do_write(3'd3, 32'd2);
    do_write(3'd2, 32'd0);
    bcd_convert(123456, 1'b0);
    check("bcd_123456", rdata, 32'h123456);
    bcd_convert(123456, 1'b1);
    check("bcd_poke", rdata, 32'h123456);
    for (int j = 0; j < 3; j++) bcd_convert($urandom & 32'h07FFFFFF, 1'b0);
    bcd_convert(32'h07FFFFFF, 1'b0);

    // Reset mid-conversion aborts.
    @(negedge clock);
    wr_en = 1'b1; addr = 3'd4; wdata = 32'd999;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    repeat (5) @(posedge clock);
    do_reset();
    check("bcd_abort_busy", busy, 1'b0);
    check_model("bcd_abort", 3'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
